// File: rtl/discriminator_seq.sv
// Time-multiplexed 9-3-1 discriminator: one shared signed MAC evaluates the ReLU hidden layer
// serially, then the linear output neuron, behind valid/ready handshakes.
module discriminator_seq #(
    parameter int WIDTH       = 32,
    parameter int FRAC        = 16,
    parameter int N_INPUT     = 9,
    parameter int N_NEURON_L2 = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [N_INPUT*WIDTH-1:0]             pix,
    input  logic [N_INPUT*N_NEURON_L2*WIDTH-1:0] w_L2,
    input  logic [N_NEURON_L2*WIDTH-1:0]         b_L2,
    input  logic [N_NEURON_L2*WIDTH-1:0]         w_L3,
    input  logic [WIDTH-1:0]                     b_L3,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIDTH-1:0]                     score,
    output logic                                 is_real
);
    localparam int PW   = 2 * WIDTH;
    localparam int ACCW = 2 * WIDTH + 4;
    localparam int KW   = $clog2(N_INPUT + 1);
    localparam int NW   = $clog2(N_NEURON_L2 + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_L2_MAC, S_L2_ACT, S_L3_MAC, S_L3_ACT, S_OUT
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACCW-1:0]    acc_q, acc_d;
    logic [KW-1:0]             k_q, k_d;
    logic [NW-1:0]             n_q, n_d;
    logic [N_INPUT*WIDTH-1:0]  pix_q, pix_d;
    logic [N_NEURON_L2*WIDTH-1:0] h_q, h_d;
    logic                      out_valid_q, out_valid_d;
    logic                      in_ready_q, in_ready_d;
    logic [WIDTH-1:0]          score_q, score_d;
    logic                      is_real_q, is_real_d;

    logic signed [WIDTH-1:0]   op_a, op_b, bias;
    logic signed [PW-1:0]      prod, term;
    logic signed [ACCW-1:0]    mac_sum, bias_sum;
    logic [WIDTH-1:0]          sat_v, relu_v;
    int unsigned               k_i, n_i;

    // Clamp the wide accumulator into the signed WIDTH range.
    function automatic logic [WIDTH-1:0] sat(input logic signed [ACCW-1:0] x);
        if (x[ACCW-1:WIDTH-1] == '0 || x[ACCW-1:WIDTH-1] == '1)
            return x[WIDTH-1:0];
        else if (x[ACCW-1])
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    always_comb begin
        k_i = 32'(k_q);
        n_i = 32'(n_q);
        op_a = '0;
        op_b = '0;
        if (state_q == S_L3_MAC) begin
            op_a = h_q[k_i*WIDTH +: WIDTH];
            op_b = w_L3[k_i*WIDTH +: WIDTH];
        end else begin
            op_a = pix_q[k_i*WIDTH +: WIDTH];
            op_b = w_L2[(n_i*N_INPUT + k_i)*WIDTH +: WIDTH];
        end
        prod     = PW'(op_a) * PW'(op_b);
        term     = prod >>> FRAC;
        mac_sum  = acc_q + ACCW'(term);
        bias     = (state_q == S_L3_ACT) ? b_L3 : b_L2[n_i*WIDTH +: WIDTH];
        bias_sum = acc_q + ACCW'(bias);
        sat_v    = sat(bias_sum);
        relu_v   = sat_v[WIDTH-1] ? '0 : sat_v;
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        k_d       = k_q;
        n_d       = n_q;
        pix_d     = pix_q;
        h_d       = h_q;
        score_d   = score_q;
        is_real_d = is_real_q;
        unique case (state_q)
            S_IDLE: if (in_valid) begin
                pix_d   = pix;
                acc_d   = '0;
                k_d     = '0;
                n_d     = '0;
                state_d = S_L2_MAC;
            end
            S_L2_MAC: begin
                acc_d = mac_sum;
                if (k_q == KW'(N_INPUT - 1)) begin
                    k_d     = '0;
                    state_d = S_L2_ACT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_L2_ACT: begin
                h_d[n_i*WIDTH +: WIDTH] = relu_v;
                acc_d = '0;
                k_d   = '0;
                if (n_q < NW'(N_NEURON_L2 - 1)) begin
                    n_d     = n_q + 1'b1;
                    state_d = S_L2_MAC;
                end else begin
                    state_d = S_L3_MAC;
                end
            end
            S_L3_MAC: begin
                acc_d = mac_sum;
                if (k_q == KW'(N_NEURON_L2 - 1)) begin
                    k_d     = '0;
                    state_d = S_L3_ACT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_L3_ACT: begin
                score_d   = sat_v;
                is_real_d = ~sat_v[WIDTH-1];
                state_d   = S_OUT;
            end
            S_OUT: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Handshake flags are registered copies of the next state.
        out_valid_d = (state_d == S_OUT);
        in_ready_d  = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            k_q         <= '0;
            n_q         <= '0;
            pix_q       <= '0;
            h_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            score_q     <= '0;
            is_real_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            n_q         <= n_d;
            pix_q       <= pix_d;
            h_q         <= h_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            score_q     <= score_d;
            is_real_q   <= is_real_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign score     = score_q;
    assign is_real   = is_real_q;
endmodule

// File: tb/tb_discriminator_seq.sv
// Directed bench for discriminator_seq: expected results from a reference model are queued at
// accept and compared when the result is presented.
module tb_discriminator_seq;
    localparam int W   = 32;
    localparam int NI  = 9;
    localparam int NH  = 3;
    localparam int ONE = 65536;
    localparam int MAXI = 32'h7FFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, is_real;
    logic [W-1:0] score;

    int pix_a [NI];
    int wl2_a [NI*NH];
    int bl2_a [NH];
    int wl3_a [NH];
    int bl3_v;

    logic [NI*W-1:0]    pix;
    logic [NI*NH*W-1:0] w_l2;
    logic [NH*W-1:0]    b_l2, w_l3;
    logic [W-1:0]       b_l3;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [32:0] sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        pix = '0; w_l2 = '0; b_l2 = '0; w_l3 = '0;
        for (int i = 0; i < NI; i++) pix[i*W +: W] = pix_a[i];
        for (int i = 0; i < NI*NH; i++) w_l2[i*W +: W] = wl2_a[i];
        for (int i = 0; i < NH; i++) begin
            b_l2[i*W +: W] = bl2_a[i];
            w_l3[i*W +: W] = wl3_a[i];
        end
        b_l3 = bl3_v;
    end

    discriminator_seq #(.WIDTH(32), .FRAC(16), .N_INPUT(9), .N_NEURON_L2(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pix(pix),
        .w_L2(w_l2), .b_L2(b_l2), .w_L3(w_l3), .b_L3(b_l3),
        .out_valid(out_valid), .out_ready(out_ready), .score(score), .is_real(is_real)
    );

    function automatic longint sat64(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic logic [32:0] model();
        longint acc, s;
        longint h [NH];
        for (int n = 0; n < NH; n++) begin
            acc = 0;
            for (int k = 0; k < NI; k++)
                acc += (longint'(pix_a[k]) * longint'(wl2_a[n*NI+k])) >>> 16;
            h[n] = sat64(acc + longint'(bl2_a[n]));
            if (h[n] < 0) h[n] = 0;
        end
        acc = 0;
        for (int j = 0; j < NH; j++) acc += (h[j] * longint'(wl3_a[j])) >>> 16;
        s = sat64(acc + longint'(bl3_v));
        return {(s >= 0) ? 1'b1 : 1'b0, 32'(s)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int p, input int w2, input int b2, input int w3, input int b3);
        for (int i = 0; i < NI; i++) pix_a[i] = p;
        for (int i = 0; i < NI*NH; i++) wl2_a[i] = w2;
        for (int i = 0; i < NH; i++) begin
            bl2_a[i] = b2;
            wl3_a[i] = w3;
        end
        bl3_v = b3;
    endtask

    task automatic set_pix(input int p);
        for (int i = 0; i < NI; i++) pix_a[i] = p;
    endtask

    task automatic accept_image(input string tag, output int e0);
        int t;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        chk({tag, " in_ready_before_accept"}, in_ready, 1'b1);
        sb.push_back(model());
        e0 = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " in_ready_busy"}, in_ready, 1'b0);
    endtask

    task automatic wait_output(input string tag, input int e0, output logic [31:0] obs);
        int t;
        logic [32:0] exp;
        t = 0;
        obs = 'x;
        while (!out_valid && t < 200) begin @(negedge clk); t++; end
        chk({tag, " out_valid_timeout"}, out_valid, 1'b1);
        if (!out_valid) return;
        chk({tag, " latency"}, cyc - e0, 34);
        chk({tag, " scoreboard_nonempty"}, (sb.size() > 0), 1'b1);
        if (sb.size() == 0) return;
        exp = sb.pop_front();
        chk({tag, " score"}, score, exp[31:0]);
        chk({tag, " is_real"}, is_real, exp[32]);
        obs = score;
        if (out_ready) begin
            @(negedge clk);
            chk({tag, " out_valid_drop"}, out_valid, 1'b0);
            chk({tag, " in_ready_back"}, in_ready, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e0b, t, hi_cnt;
        logic [31:0] obs;

        set_cfg(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset score", score, 32'h0);
        chk("reset is_real", is_real, 1'b0);
        chk("reset in_ready", in_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: all ones, bias -1.0
        set_cfg(ONE, ONE, 0, ONE, -ONE);
        accept_image("t1", e0);
        wait_output("t1", e0, obs);
        chk("t1 const", obs, 32'h001A_0000);

        // Test 2: negative hidden sums clipped by ReLU
        set_cfg(ONE, -ONE, 0, ONE, -ONE/2);
        accept_image("t2", e0);
        wait_output("t2", e0, obs);
        chk("t2 const", obs, 32'hFFFF_8000);

        // Test 3: saturation of hidden layer and output
        set_cfg(MAXI, MAXI, 0, ONE, 0);
        accept_image("t3a", e0);
        wait_output("t3a", e0, obs);
        chk("t3a const", obs, 32'h7FFF_FFFF);
        set_cfg(MAXI, MAXI, 0, -ONE, 0);
        accept_image("t3b", e0);
        wait_output("t3b", e0, obs);
        chk("t3b const", obs, 32'h8000_0000);

        // Test 4: output backpressure with in_valid toggling
        set_cfg(ONE, ONE, 0, ONE, -ONE);
        out_ready = 1'b0;
        accept_image("t4", e0);
        wait_output("t4", e0, obs);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            set_pix((i % 2 == 1) ? 2 * ONE : ONE);
            @(negedge clk);
            chk("t4 hold out_valid", out_valid, 1'b1);
            chk("t4 hold score", score, 32'h001A_0000);
            chk("t4 hold is_real", is_real, 1'b1);
            chk("t4 hold in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        set_pix(ONE);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4 release out_valid", out_valid, 1'b0);
        chk("t4 release in_ready", in_ready, 1'b1);
        @(negedge clk);
        chk("t4 no extra capture", out_valid, 1'b0);

        // Test 5: reset in the middle of the hidden layer
        accept_image("t5", e0);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5 rst out_valid", out_valid, 1'b0);
        chk("t5 rst in_ready", in_ready, 1'b1);
        sb.delete();
        hi_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) hi_cnt++;
        end
        chk("t5 discarded no output", hi_cnt, 0);
        accept_image("t5r", e0);
        wait_output("t5r", e0, obs);
        chk("t5r const", obs, 32'h001A_0000);

        // Test 6: back-to-back images with in_valid held high, pix changed after accept
        set_cfg(ONE, ONE, 0, ONE, -ONE);
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        chk("t6a in_ready", in_ready, 1'b1);
        sb.push_back(model());
        e0 = cyc + 1;
        @(negedge clk);
        set_pix(3 * ONE);
        wait_output("t6a", e0, obs);
        chk("t6a const", obs, 32'h001A_0000);
        set_cfg(ONE, -ONE, 0, ONE, -ONE/2);
        sb.push_back(model());
        e0b = cyc + 1;
        chk("t6 initiation interval", e0b - e0, 36);
        @(negedge clk);
        in_valid = 1'b0;
        set_pix(3 * ONE);
        wait_output("t6b", e0b, obs);
        chk("t6b const", obs, 32'hFFFF_8000);
        chk("t6 scoreboard drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
